axi4_lite_line_fill_arbiter: RTL and testbench

Shares one AXI4-Lite single-beat read master between two cache clients: client 0 (instruction cache) and client 1 (data cache). It grants the master to one client at a time using round-robin arbitration. For the granted client it issues BLOCK_WORDS sequential single-word reads, assembles the words into a line buffer, and returns the whole line with a done pulse and a fault flag. It sits between the caches and the read master, and drives the master's start/address inputs.

---
 rtl/axi4_lite_line_fill_arbiter_if.sv | 22 ++
 rtl/axi4_lite_line_fill_arbiter.sv | 116 +++++++++++
 tb/tb_axi4_lite_line_fill_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/axi4_lite_line_fill_arbiter_if.sv
// Single-beat read master handshake shared by the line-fill arbiter.
// The arbiter uses the master modport. The read master, or a bench model, uses the slave modport.
interface axi4_lite_line_fill_arbiter_if #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32
);
    logic                      m_start_read;
    logic [AXI_ADDR_WIDTH-1:0] m_addr;
    logic [AXI_DATA_WIDTH-1:0] m_data;
    logic                      m_access_fault;
    logic                      m_done;

    modport master (
        output m_start_read, m_addr,
        input  m_data, m_access_fault, m_done
    );

    modport slave (
        input  m_start_read, m_addr,
        output m_data, m_access_fault, m_done
    );
endinterface

// File: rtl/axi4_lite_line_fill_arbiter.sv
// Round-robin line-fill arbiter: grants one of two cache clients the shared read master
// and assembles BLOCK_WORDS sequential single-beat reads into one line.
module axi4_lite_line_fill_arbiter #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int BLOCK_WORDS    = 16
) (
    input  logic                                  clk,
    input  logic                                  arst,
    input  logic                                  i_req_0,
    input  logic                                  i_req_1,
    input  logic [AXI_ADDR_WIDTH-1:0]             i_addr_0,
    input  logic [AXI_ADDR_WIDTH-1:0]             i_addr_1,
    output logic                                  o_done_0,
    output logic                                  o_done_1,
    output logic                                  o_fault_0,
    output logic                                  o_fault_1,
    output logic [BLOCK_WORDS*AXI_DATA_WIDTH-1:0] o_line,
    output logic                                  o_busy,
    axi4_lite_line_fill_arbiter_if.master         m_bus
);
    localparam int BYTES    = AXI_DATA_WIDTH / 8;
    localparam int WORD_OFF = $clog2(BYTES);
    localparam int CNT_W    = $clog2(BLOCK_WORDS);
    localparam int LINE_OFF = WORD_OFF + CNT_W;
    localparam int LINE_W   = BLOCK_WORDS * AXI_DATA_WIDTH;
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                               state, state_nxt;
    logic [CNT_W-1:0]                     cnt;
    logic                                 grant, last_grant, fault_reg;
    logic [AXI_ADDR_WIDTH-LINE_OFF-1:0]   base_hi;
    logic [LINE_W-1:0]                    line_buf;
    logic                                 req_any, sel;

    // The in-line offset bits of the client addresses are dropped by design.
    logic unused_offset_bits;
    assign unused_offset_bits = ^{i_addr_0[LINE_OFF-1:0], i_addr_1[LINE_OFF-1:0]};

    // On a tie the client that was not served last wins.
    assign req_any = i_req_0 | i_req_1;
    assign sel     = (i_req_0 & i_req_1) ? ~last_grant : i_req_1;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        state_nxt          = state;
        m_bus.m_start_read = 1'b0;
        m_bus.m_addr       = '0;
        o_done_0           = 1'b0;
        o_done_1           = 1'b0;
        o_fault_0          = 1'b0;
        o_fault_1          = 1'b0;
        o_busy             = (state != IDLE);
        unique case (state)
            IDLE: if (req_any) state_nxt = ISSUE;
            ISSUE: begin
                m_bus.m_start_read = 1'b1;
                m_bus.m_addr       = {base_hi, cnt, {WORD_OFF{1'b0}}};
                state_nxt          = WAIT;
            end
            WAIT: begin
                m_bus.m_addr = {base_hi, cnt, {WORD_OFF{1'b0}}};
                if (m_bus.m_done)
                    state_nxt = (m_bus.m_access_fault || cnt == LAST_WORD) ? DONE : ISSUE;
            end
            DONE: begin
                o_done_0  = ~grant;
                o_done_1  = grant;
                o_fault_0 = ~grant & fault_reg;
                o_fault_1 = grant & fault_reg;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the line buffer is reset here as well, because o_line must read 0 out of reset.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            cnt        <= '0;
            grant      <= 1'b0;
            last_grant <= 1'b1;
            fault_reg  <= 1'b0;
            base_hi    <= '0;
            line_buf   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
            unique case (state)
                IDLE: if (req_any) begin
                    grant     <= sel;
                    base_hi   <= sel ? i_addr_1[AXI_ADDR_WIDTH-1:LINE_OFF]
                                     : i_addr_0[AXI_ADDR_WIDTH-1:LINE_OFF];
                    cnt       <= '0;
                    fault_reg <= 1'b0;
                    line_buf  <= '0;
                end
                WAIT: if (m_bus.m_done) begin
                    line_buf[cnt*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] <= m_bus.m_data;
                    if (m_bus.m_access_fault) fault_reg <= 1'b1;
                    else if (cnt != LAST_WORD) cnt <= cnt + 1'b1;
                end
                DONE: last_grant <= grant;
                default: ;
            endcase
        end
    end

    assign o_line = line_buf;
endmodule

// File: tb/tb_axi4_lite_line_fill_arbiter.sv
// Directed bench for the line-fill arbiter: BLOCK_WORDS=4, read master model with 3-cycle latency.
module tb_axi4_lite_line_fill_arbiter;
    localparam int AW = 64;
    localparam int DW = 32;
    localparam int BW = 4;

    logic           clk = 1'b0;
    logic           arst;
    logic           i_req_0, i_req_1;
    logic [AW-1:0]  i_addr_0, i_addr_1;
    logic           o_done_0, o_done_1, o_fault_0, o_fault_1, o_busy;
    logic [BW*DW-1:0] o_line;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    axi4_lite_line_fill_arbiter_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

    axi4_lite_line_fill_arbiter #(
        .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .BLOCK_WORDS(BW)
    ) dut (
        .clk(clk), .arst(arst),
        .i_req_0(i_req_0), .i_req_1(i_req_1),
        .i_addr_0(i_addr_0), .i_addr_1(i_addr_1),
        .o_done_0(o_done_0), .o_done_1(o_done_1),
        .o_fault_0(o_fault_0), .o_fault_1(o_fault_1),
        .o_line(o_line), .o_busy(o_busy),
        .m_bus(bus.master)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Read master model: data is a function of the beat address; one address can be made to fault.
    function automatic logic [31:0] exp_word(input logic [63:0] a);
        if (a[15:12] == 4'h1) return 32'hA0 + {30'b0, a[3:2]};
        return {a[15:0], 16'h00A0} + {30'b0, a[3:2]};
    endfunction

    logic [AW-1:0] fault_addr = '1;
    logic [AW-1:0] cur_addr;
    int            lat = 0;
    logic [AW-1:0] start_q[$];
    int            cyc_q[$];
    int            prev_done = 0;

    always @(negedge clk) begin
        if (arst) begin
            lat = 0;
            bus.m_done = 1'b0;
            bus.m_access_fault = 1'b0;
            bus.m_data = '0;
        end else begin
            bus.m_done = 1'b0;
            bus.m_access_fault = 1'b0;
            if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    bus.m_done = 1'b1;
                    bus.m_data = exp_word(cur_addr);
                    bus.m_access_fault = (cur_addr == fault_addr);
                end
            end
            if (bus.m_start_read) begin
                cur_addr = bus.m_addr;
                lat = 3;
                start_q.push_back(bus.m_addr);
                cyc_q.push_back(cyc);
            end
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_start"}, bus.m_start_read, 1'b0);
        check({tag, "_maddr"}, bus.m_addr, '0);
        check({tag, "_done"}, {o_done_1, o_done_0}, 2'b00);
        check({tag, "_fault"}, {o_fault_1, o_fault_0}, 2'b00);
        check({tag, "_line"}, o_line, '0);
        check({tag, "_busy"}, o_busy, 1'b0);
    endtask

    // Wait for the next done pulse and check client, fault, line, beat addresses and pulse width.
    task automatic wait_done(input string tag, input bit client, input logic [63:0] base,
                             input int nbeats, input bit fault, input bit drop0,
                             input bit drop1, input bit chk_gap);
        logic [127:0] exp_line;
        bit seen = 0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            seen = o_done_0 | o_done_1;
        end
        if (!seen) begin
            check({tag, "_timeout"}, 1'b0, 1'b1);
            return;
        end
        check({tag, "_client"}, {o_done_1, o_done_0}, client ? 2'b10 : 2'b01);
        check({tag, "_fault"}, {o_fault_1, o_fault_0}, {client & fault, ~client & fault});
        exp_line = '0;
        for (int w = 0; w < BW; w++)
            if (w < nbeats) exp_line[w*DW +: DW] = exp_word(base + 64'(4*w));
        check({tag, "_line"}, o_line, exp_line);
        check({tag, "_nstart"}, start_q.size(), nbeats);
        for (int i = 0; i < start_q.size() && i < nbeats; i++)
            check($sformatf("%s_addr%0d", tag, i), start_q[i], base + 64'(4*i));
        if (chk_gap && cyc_q.size() > 0)
            check({tag, "_gap"}, cyc_q[0] - prev_done, 2);
        prev_done = cyc;
        start_q.delete();
        cyc_q.delete();
        if (drop0) i_req_0 = 1'b0;
        if (drop1) i_req_1 = 1'b0;
        @(negedge clk);
        check({tag, "_pulse"}, {o_done_1, o_done_0}, 2'b00);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        start_q.delete();
        cyc_q.delete();
    endtask

    initial begin
        arst = 1'b1;
        i_req_0 = 1'b0; i_req_1 = 1'b0;
        i_addr_0 = '0;  i_addr_1 = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        arst = 1'b0;
        start_q.delete();
        cyc_q.delete();
        @(negedge clk);

        // Single request from client 0 at an unaligned address.
        i_addr_0 = 64'h1004; i_req_0 = 1'b1;
        wait_done("single", 1'b0, 64'h1000, 4, 1'b0, 1'b1, 1'b0, 1'b0);
        check("single_line_const", o_line, 128'h000000A3_000000A2_000000A1_000000A0);
        check("single_busy_after", o_busy, 1'b0);

        // Tie right after reset: client 0 first, client 1 immediately after.
        do_reset();
        i_addr_0 = 64'h2000; i_addr_1 = 64'h3000;
        i_req_0 = 1'b1; i_req_1 = 1'b1;
        wait_done("tie0", 1'b0, 64'h2000, 4, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done("tie1", 1'b1, 64'h3000, 4, 1'b0, 1'b0, 1'b1, 1'b1);

        // Fairness: both held for four fills.
        i_addr_0 = 64'h7000; i_addr_1 = 64'h8000;
        i_req_0 = 1'b1; i_req_1 = 1'b1;
        wait_done("fair0", 1'b0, 64'h7000, 4, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_done("fair1", 1'b1, 64'h8000, 4, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done("fair2", 1'b0, 64'h7000, 4, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_done("fair3", 1'b1, 64'h8000, 4, 1'b0, 1'b1, 1'b1, 1'b1);

        // Fault on beat 2 of client 1, then a clean fill.
        fault_addr = 64'h4008;
        i_addr_1 = 64'h4000; i_req_1 = 1'b1;
        wait_done("fault", 1'b1, 64'h4000, 3, 1'b1, 1'b0, 1'b1, 1'b0);
        check("fault_word3", o_line[3*DW +: DW], 32'h0);
        fault_addr = '1;
        i_addr_0 = 64'h1004; i_req_0 = 1'b1;
        wait_done("after_fault", 1'b0, 64'h1000, 4, 1'b0, 1'b1, 1'b0, 1'b0);

        // Late request from client 1 during client 0's fill.
        i_addr_0 = 64'h9000; i_req_0 = 1'b1;
        for (int k = 0; k < 50 && start_q.size() == 0; k++) @(negedge clk);
        check("late_started", start_q.size() > 0, 1'b1);
        i_addr_1 = 64'hA000; i_req_1 = 1'b1;
        wait_done("late0", 1'b0, 64'h9000, 4, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_done("late1", 1'b1, 64'hA000, 4, 1'b0, 1'b0, 1'b1, 1'b1);

        // Reset while waiting on beat 1.
        i_addr_0 = 64'h6000; i_req_0 = 1'b1;
        for (int k = 0; k < 50 && start_q.size() < 2; k++) @(negedge clk);
        check("midrst_beat1", start_q.size(), 2);
        @(negedge clk);
        check("midrst_busy", o_busy, 1'b1);
        arst = 1'b1;
        i_req_0 = 1'b0;
        @(posedge clk);
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        arst = 1'b0;
        start_q.delete();
        cyc_q.delete();
        i_addr_1 = 64'h5000; i_req_1 = 1'b1;
        wait_done("post_rst", 1'b1, 64'h5000, 4, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
